// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, digit indices and decode helpers for the clock set controller.
//   set_state_t : front-panel state (two view states, six digit-edit states)
//   IDX_*       : bit positions of each digit in the inc / update vectors
package clock_pkg;

    typedef enum logic [2:0] {
        VIEW_HM,
        VIEW_S,
        EDIT_H2,
        EDIT_H1,
        EDIT_M2,
        EDIT_M1,
        EDIT_S2,
        EDIT_S1
    } set_state_t;

    localparam int IDX_S1 = 0;
    localparam int IDX_S2 = 1;
    localparam int IDX_M1 = 2;
    localparam int IDX_M2 = 3;
    localparam int IDX_H1 = 4;
    localparam int IDX_H2 = 5;

    function automatic logic is_edit(input set_state_t s);
        return s != VIEW_HM && s != VIEW_S;
    endfunction

    // One-hot digit mask {H2,H1,M2,M1,S2,S1}; zero in view states.
    function automatic logic [5:0] digit_mask(input set_state_t s);
        return (s == EDIT_H2) ? 6'(1 << IDX_H2) :
               (s == EDIT_H1) ? 6'(1 << IDX_H1) :
               (s == EDIT_M2) ? 6'(1 << IDX_M2) :
               (s == EDIT_M1) ? 6'(1 << IDX_M1) :
               (s == EDIT_S2) ? 6'(1 << IDX_S2) :
               (s == EDIT_S1) ? 6'(1 << IDX_S1) : 6'b0;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_blink_gen.sv
// blink_gen: half-period blink phase generator for the digit under edit.
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : 0 holds the counter cleared and blink at 1
//   restart    : clears the counter and forces blink to 1 (fresh visible phase)
//   blink      : 1 = visible, 0 = blanked; toggles every BLINK_HALF_PERIOD cycles
module blink_gen #(
    parameter int BLINK_HALF_PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic blink
);

    localparam int CW = $clog2(BLINK_HALF_PERIOD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable || restart) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == CW'(BLINK_HALF_PERIOD - 1)) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: front-panel controller turning mode/next/inc buttons into view, edit and increment controls.
//   clk, rst_n                 : clock, synchronous active-low reset
//   btn_mode, btn_next, btn_inc: debounced button levels
//   hour_miniute, second       : view selects (HH:MM, MM:SS)
//   update_H2..update_S1       : one-hot digit-edit selects
//   blink                      : blink phase of the edited digit
//   inc                        : one-cycle increment strobe {H2,H1,M2,M1,S2,S1}
//   run_en                     : time counters may advance (view states only)
// Optional: define CLOCK_SET_TIMEOUT_EN to abandon an idle edit after TIMEOUT_CYCLES.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 25_000_000,
    parameter int TIMEOUT_CYCLES    = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic       hour_miniute,
    output logic       second,
    output logic       update_H1,
    output logic       update_H2,
    output logic       update_M1,
    output logic       update_M2,
    output logic       update_S1,
    output logic       update_S2,
    output logic       blink,
    output logic [5:0] inc,
    output logic       run_en
);

    set_state_t state, next_state;
    logic [2:0] btn, btn_q, edge_q;
    logic [5:0] next_inc;
    logic       mode_e, next_e, inc_e, timeout;

    assign btn = {btn_mode, btn_next, btn_inc};
    assign {mode_e, next_e, inc_e} = edge_q;

    // Edges are registered so every output moves one cycle after the edge register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q  <= '0;
            edge_q <= '0;
            state  <= VIEW_HM;
            inc    <= '0;
        end else begin
            btn_q  <= btn;
            edge_q <= btn & ~btn_q;
            state  <= next_state;
            inc    <= next_inc;
        end
    end

    // One edge acted on per cycle: mode > next > inc > timeout.
    always_comb begin
        next_state = state;
        next_inc   = '0;
        if (mode_e)
            next_state = (state == VIEW_HM) ? VIEW_S : VIEW_HM;
        else if (next_e)
            next_state = (state == VIEW_HM) ? EDIT_H2 :
                         (state == VIEW_S)  ? EDIT_S2 :
                         (state == EDIT_S1) ? VIEW_HM : set_state_t'(state + 3'd1);
        else if (inc_e)
            next_inc = digit_mask(state);
        else if (timeout)
            next_state = VIEW_HM;
    end

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] idle;

    always_ff @(posedge clk) begin
        if (!rst_n || |edge_q || next_state != state || !is_edit(state))
            idle <= '0;
        else
            idle <= idle + 1'b1;
    end

    assign timeout = is_edit(state) && idle == TW'(TIMEOUT_CYCLES - 1);
`else
    // Edit sessions never expire in this build.
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    // Restart on edit entry and on each accepted inc so a changed digit shows a full phase.
    blink_gen #(
        .BLINK_HALF_PERIOD(BLINK_HALF_PERIOD)
    ) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (is_edit(next_state)),
        .restart(|next_inc || (is_edit(next_state) && next_state != state)),
        .blink  (blink)
    );

    assign hour_miniute = state == VIEW_HM;
    assign second       = state == VIEW_S;
    assign {update_H2, update_H1, update_M2, update_M1, update_S2, update_S1} = digit_mask(state);
    assign run_en       = !is_edit(state);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: table-driven self-checking bench for clock_set_ctrl.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
    logic       hour_miniute, second, blink, run_en;
    logic       update_H1, update_H2, update_M1, update_M2, update_S1, update_S2;
    logic [5:0] inc;
    logic [7:0] sel;
    int         total = 0, bad = 0;

    typedef struct {
        logic [2:0] btn;
        logic [7:0] sel;
        logic [5:0] inc;
        logic       run;
    } vec_t;

    vec_t tv[22];

    clock_set_ctrl #(
        .BLINK_HALF_PERIOD(4),
        .TIMEOUT_CYCLES   (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_mode    (btn_mode),
        .btn_next    (btn_next),
        .btn_inc     (btn_inc),
        .hour_miniute(hour_miniute),
        .second      (second),
        .update_H1   (update_H1),
        .update_H2   (update_H2),
        .update_M1   (update_M1),
        .update_M2   (update_M2),
        .update_S1   (update_S1),
        .update_S2   (update_S2),
        .blink       (blink),
        .inc         (inc),
        .run_en      (run_en)
    );

    always #5 clk = ~clk;

    assign sel = {hour_miniute, second, update_H2, update_H1, update_M2, update_M1, update_S2, update_S1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one button pattern for one cycle, then wait for its registered effect.
    task automatic press(input logic [2:0] b);
        {btn_mode, btn_next, btn_inc} = b;
        @(negedge clk);
        {btn_mode, btn_next, btn_inc} = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        tv[0]  = '{3'b100, 8'b0100_0000, 6'b000000, 1'b1};
        tv[1]  = '{3'b100, 8'b1000_0000, 6'b000000, 1'b1};
        tv[2]  = '{3'b001, 8'b1000_0000, 6'b000000, 1'b1};
        tv[3]  = '{3'b010, 8'b0010_0000, 6'b000000, 1'b0};
        tv[4]  = '{3'b001, 8'b0010_0000, 6'b100000, 1'b0};
        tv[5]  = '{3'b010, 8'b0001_0000, 6'b000000, 1'b0};
        tv[6]  = '{3'b001, 8'b0001_0000, 6'b010000, 1'b0};
        tv[7]  = '{3'b010, 8'b0000_1000, 6'b000000, 1'b0};
        tv[8]  = '{3'b010, 8'b0000_0100, 6'b000000, 1'b0};
        tv[9]  = '{3'b001, 8'b0000_0100, 6'b000100, 1'b0};
        tv[10] = '{3'b010, 8'b0000_0010, 6'b000000, 1'b0};
        tv[11] = '{3'b001, 8'b0000_0010, 6'b000010, 1'b0};
        tv[12] = '{3'b010, 8'b0000_0001, 6'b000000, 1'b0};
        tv[13] = '{3'b001, 8'b0000_0001, 6'b000001, 1'b0};
        tv[14] = '{3'b010, 8'b1000_0000, 6'b000000, 1'b1};
        tv[15] = '{3'b100, 8'b0100_0000, 6'b000000, 1'b1};
        tv[16] = '{3'b010, 8'b0000_0010, 6'b000000, 1'b0};
        tv[17] = '{3'b110, 8'b1000_0000, 6'b000000, 1'b1};
        tv[18] = '{3'b010, 8'b0010_0000, 6'b000000, 1'b0};
        tv[19] = '{3'b011, 8'b0001_0000, 6'b000000, 1'b0};
        tv[20] = '{3'b110, 8'b1000_0000, 6'b000000, 1'b1};
        tv[21] = '{3'b101, 8'b0100_0000, 6'b000000, 1'b1};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("idle_sel", 32'(sel), 32'h80);
            chk("idle_run", 32'(run_en), 1);
            chk("idle_blink", 32'(blink), 1);
            chk("idle_inc", 32'(inc), 0);
        end

        for (int i = 0; i < 22; i++) begin
            press(tv[i].btn);
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(tv[i].sel));
            chk($sformatf("vec%0d_inc", i), 32'(inc), 32'(tv[i].inc));
            chk($sformatf("vec%0d_run", i), 32'(run_en), 32'(tv[i].run));
            chk($sformatf("vec%0d_onehot", i), 32'($onehot(sel)), 1);
        end

        press(3'b100);
        repeat (4) press(3'b010);
        chk("to_m1", 32'(sel), 32'h04);
        btn_inc = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            chk($sformatf("hold_inc_t%0d", t), 32'(inc), (t == 2) ? 32'h04 : 32'h0);
            if (t >= 2)
                chk($sformatf("hold_blink_t%0d", t), 32'(blink), (t >= 6 && t <= 9) ? 32'h0 : 32'h1);
            if (t == 6)
                btn_inc = 1'b0;
        end

        btn_inc = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'h80);
        chk("rst_inc", 32'(inc), 0);
        chk("rst_blink", 32'(blink), 1);
        btn_inc = 1'b0;
        btn_next = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_edge_wait", 32'(sel), 32'h80);
        @(negedge clk);
        chk("rel_edge_h2", 32'(sel), 32'h20);
        btn_next = 1'b0;

        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
`ifdef CLOCK_SET_TIMEOUT_EN
            if (t == 19)
                chk("timeout_before", 32'(sel), 32'h20);
            if (t == 20)
                chk("timeout_fire", 32'(sel), 32'h80);
`else
            if (t == 20 || t == 100)
                chk($sformatf("no_timeout_t%0d", t), 32'(sel), 32'h20);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
